// File: rtl/rst_seq_if.sv
// Bundle of the bring-up sequencer's status inputs and reset/run outputs.
// The sequencer uses the slave view; whatever drives the status flags uses the master view.
interface rst_seq_if;
  logic       locked;
  logic       pcie_ready_sync;
  logic       xwopen_sync;
  logic       soft_rst_req;
  logic       core_rst;
  logic       run;
  logic       xw_rise;
  logic       xw_fall;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;

  modport master (
    output locked, pcie_ready_sync, xwopen_sync, soft_rst_req,
    input  core_rst, run, xw_rise, xw_fall, state, lock_loss_cnt
  );

  modport slave (
    input  locked, pcie_ready_sync, xwopen_sync, soft_rst_req,
    output core_rst, run, xw_rise, xw_fall, state, lock_loss_cnt
  );
endinterface

// File: rtl/rst_seq.sv
// Reset and bring-up sequencer for the multiexp datapath (out_clk domain).
// Walks LOCK -> LINK -> HOLD -> RUN, holds core reset for HOLD_CYCLES after
// PLL lock and PCIe link are both up, drops back whenever either is lost,
// qualifies xwopen edges to RUN only, and counts lock-loss events.
module rst_seq #(
  parameter int HOLD_CYCLES = 64
) (
  input  logic      out_clk,
  input  logic      rst,
  rst_seq_if.slave  bus
);

  // Counter only has to reach HOLD_CYCLES-1; one spare value keeps the
  // width rule simple for every legal HOLD_CYCLES, including 1.
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOCK = 2'd0,
    S_LINK = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [7:0]      loss_q, loss_d;
  logic            core_rst_q, core_rst_d;
  logic            run_q, run_d;
  logic            xw_q, xw_d;
  logic            xw_rise_q, xw_rise_d;
  logic            xw_fall_q, xw_fall_d;
  logic            in_hold_or_run;

  assign in_hold_or_run = (state_q == S_HOLD) || (state_q == S_RUN);

  // Next-state, hold counter and lock-loss counter; earlier branches win.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;

    if (!bus.locked && (state_q != S_LOCK)) begin
      // Losing the PLL overrides everything, including soft reset and link loss.
      state_d = S_LOCK;
      if (loss_q != 8'hFF) begin
        loss_d = loss_q + 8'd1;
      end
    end else if ((state_q == S_LOCK) && bus.locked) begin
      state_d = S_LINK;
    end else if (!bus.pcie_ready_sync && in_hold_or_run) begin
      // Link loss beats a simultaneous soft reset request.
      state_d = S_LINK;
    end else if ((state_q == S_LINK) && bus.pcie_ready_sync) begin
      state_d = S_HOLD;
      cnt_d   = '0;
    end else if (bus.soft_rst_req && in_hold_or_run) begin
      // Restart the hold window from zero, even if already mid-HOLD.
      state_d = S_HOLD;
      cnt_d   = '0;
    end else if (state_q == S_HOLD) begin
      if (cnt_q == HOLD_LAST) begin
        state_d = S_RUN;
      end else begin
        cnt_d = cnt_q + HW'(1);
      end
    end
  end

  // Registered outputs are derived from the next state so they change on the
  // same edge as the state register; xwopen edges only count inside RUN.
  always_comb begin
    core_rst_d = (state_d != S_RUN);
    run_d      = (state_d == S_RUN);
    xw_d       = bus.xwopen_sync;
    xw_rise_d  = (state_d == S_RUN) &  bus.xwopen_sync & ~xw_q;
    xw_fall_d  = (state_d == S_RUN) & ~bus.xwopen_sync &  xw_q;
  end

  // State and output registers; rst asserts asynchronously, releases on out_clk.
  always_ff @(posedge out_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOCK;
      cnt_q      <= '0;
      loss_q     <= '0;
      core_rst_q <= 1'b1;
      run_q      <= 1'b0;
      xw_q       <= 1'b0;
      xw_rise_q  <= 1'b0;
      xw_fall_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_q     <= loss_d;
      core_rst_q <= core_rst_d;
      run_q      <= run_d;
      xw_q       <= xw_d;
      xw_rise_q  <= xw_rise_d;
      xw_fall_q  <= xw_fall_d;
    end
  end

  assign bus.core_rst      = core_rst_q;
  assign bus.run           = run_q;
  assign bus.xw_rise       = xw_rise_q;
  assign bus.xw_fall       = xw_fall_q;
  assign bus.state         = state_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with HOLD_CYCLES=4.
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_rst_seq;
  localparam int H = 4;
  localparam logic [1:0] LOCK = 2'd0, LINK = 2'd1, HOLD = 2'd2, RUN = 2'd3;

  logic out_clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_loss;

  rst_seq_if bus ();

  rst_seq #(.HOLD_CYCLES(H)) dut (
    .out_clk (out_clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial out_clk = 1'b0;
  always #5 out_clk = ~out_clk;

  // Advance one rising edge and settle.
  task automatic step;
    @(posedge out_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.locked = 1'b0; bus.pcie_ready_sync = 1'b0;
    bus.xwopen_sync = 1'b0; bus.soft_rst_req = 1'b0;
    step; step;
    checks++; if (bus.state !== LOCK) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, LOCK); end
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL reset_core_rst got=%b exp=1", bus.core_rst); end
    checks++; if (bus.run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", bus.run); end
    checks++; if ({bus.xw_rise, bus.xw_fall} !== 2'b00) begin failures++; $display("FAIL reset_xw got=%b%b exp=00", bus.xw_rise, bus.xw_fall); end
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.lock_loss_cnt); end
    rst = 1'b0;
    exp_loss = 0;
    $display("test_reset done");
  endtask

  // locked rises in cycle 2, pcie in cycle 5: LINK at edge 3, HOLD 6..9, RUN at 10.
  task automatic test_bringup;
    logic [1:0] exp_st;
    for (int e = 1; e <= 11; e++) begin
      step;
      exp_st = (e < 3) ? LOCK : (e < 6) ? LINK : (e < 10) ? HOLD : RUN;
      checks++; if (bus.state !== exp_st) begin failures++; $display("FAIL bringup_state edge=%0d got=%0d exp=%0d", e, bus.state, exp_st); end
      checks++; if (bus.core_rst !== (exp_st != RUN)) begin failures++; $display("FAIL bringup_core_rst edge=%0d got=%b exp=%b", e, bus.core_rst, exp_st != RUN); end
      checks++; if (bus.run !== (exp_st == RUN)) begin failures++; $display("FAIL bringup_run edge=%0d got=%b exp=%b", e, bus.run, exp_st == RUN); end
      checks++; if ({bus.xw_rise, bus.xw_fall} !== 2'b00) begin failures++; $display("FAIL bringup_xw edge=%0d got=%b%b exp=00", e, bus.xw_rise, bus.xw_fall); end
      if (e == 2) bus.locked = 1'b1;
      if (e == 5) bus.pcie_ready_sync = 1'b1;
    end
    $display("test_bringup done");
  endtask

  // One-cycle lock drop in RUN: LOCK next edge, then LINK, 4x HOLD, RUN.
  task automatic test_lock_drop;
    logic [1:0] exp_st;
    bus.locked = 1'b0;
    step;
    exp_loss++;
    checks++; if (bus.state !== LOCK) begin failures++; $display("FAIL lockdrop_state got=%0d exp=%0d", bus.state, LOCK); end
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL lockdrop_core_rst got=%b exp=1", bus.core_rst); end
    checks++; if (bus.lock_loss_cnt !== 8'(exp_loss)) begin failures++; $display("FAIL lockdrop_cnt got=%0d exp=%0d", bus.lock_loss_cnt, exp_loss); end
    bus.locked = 1'b1;
    for (int i = 1; i <= 2 + H; i++) begin
      step;
      exp_st = (i == 1) ? LINK : (i <= 1 + H) ? HOLD : RUN;
      checks++; if (bus.state !== exp_st) begin failures++; $display("FAIL lockdrop_reseq_state step=%0d got=%0d exp=%0d", i, bus.state, exp_st); end
      checks++; if (bus.run !== (exp_st == RUN)) begin failures++; $display("FAIL lockdrop_reseq_run step=%0d got=%b exp=%b", i, bus.run, exp_st == RUN); end
    end
    $display("test_lock_drop done");
  endtask

  task automatic test_soft_reset;
    // Single pulse in RUN: HOLD for exactly H edges.
    bus.soft_rst_req = 1'b1; step; bus.soft_rst_req = 1'b0;
    checks++; if (bus.state !== HOLD) begin failures++; $display("FAIL soft_enter_state got=%0d exp=%0d", bus.state, HOLD); end
    checks++; if (bus.run !== 1'b0) begin failures++; $display("FAIL soft_enter_run got=%b exp=0", bus.run); end
    for (int i = 1; i <= H; i++) begin
      step;
      checks++; if (bus.run !== (i == H)) begin failures++; $display("FAIL soft_hold_run step=%0d got=%b exp=%b", i, bus.run, i == H); end
    end
    // Second pulse mid-HOLD restarts the count.
    bus.soft_rst_req = 1'b1; step; bus.soft_rst_req = 1'b0;
    step;
    bus.soft_rst_req = 1'b1; step; bus.soft_rst_req = 1'b0;
    checks++; if (bus.state !== HOLD) begin failures++; $display("FAIL soft_restart_state got=%0d exp=%0d", bus.state, HOLD); end
    for (int i = 1; i <= H; i++) begin
      step;
      checks++; if (bus.run !== (i == H)) begin failures++; $display("FAIL soft_restart_run step=%0d got=%b exp=%b", i, bus.run, i == H); end
    end
    // Soft reset together with link loss: LINK wins.
    bus.soft_rst_req = 1'b1; bus.pcie_ready_sync = 1'b0; step; bus.soft_rst_req = 1'b0;
    checks++; if (bus.state !== LINK) begin failures++; $display("FAIL soft_vs_link_state got=%0d exp=%0d", bus.state, LINK); end
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL soft_vs_link_core_rst got=%b exp=1", bus.core_rst); end
    // Soft reset in LINK is ignored.
    bus.soft_rst_req = 1'b1; step; bus.soft_rst_req = 1'b0;
    checks++; if (bus.state !== LINK) begin failures++; $display("FAIL soft_in_link_state got=%0d exp=%0d", bus.state, LINK); end
    bus.pcie_ready_sync = 1'b1; step;
    checks++; if (bus.state !== HOLD) begin failures++; $display("FAIL soft_relink_state got=%0d exp=%0d", bus.state, HOLD); end
    for (int i = 1; i <= H; i++) begin
      step;
      checks++; if (bus.run !== (i == H)) begin failures++; $display("FAIL soft_relink_run step=%0d got=%b exp=%b", i, bus.run, i == H); end
    end
    $display("test_soft_reset done");
  endtask

  task automatic test_xwopen;
    // 0->1->0 with 3 cycles high: rise at first edge seeing 1, fall at first edge seeing 0.
    bus.xwopen_sync = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step;
      checks++; if (bus.xw_rise !== (i == 1)) begin failures++; $display("FAIL xw_rise step=%0d got=%b exp=%b", i, bus.xw_rise, i == 1); end
      checks++; if (bus.xw_fall !== (i == 4)) begin failures++; $display("FAIL xw_fall step=%0d got=%b exp=%b", i, bus.xw_fall, i == 4); end
      if (i == 3) bus.xwopen_sync = 1'b0;
    end
    // Raise xwopen, then soft reset: re-entering RUN while high yields no rise.
    bus.xwopen_sync = 1'b1; step;
    checks++; if (bus.xw_rise !== 1'b1) begin failures++; $display("FAIL xw_rise_again got=%b exp=1", bus.xw_rise); end
    bus.soft_rst_req = 1'b1; step; bus.soft_rst_req = 1'b0;
    for (int i = 1; i <= H + 1; i++) begin
      step;
      checks++; if ({bus.xw_rise, bus.xw_fall} !== 2'b00) begin failures++; $display("FAIL xw_entry_high step=%0d got=%b%b exp=00", i, bus.xw_rise, bus.xw_fall); end
    end
    checks++; if (bus.state !== RUN) begin failures++; $display("FAIL xw_entry_state got=%0d exp=%0d", bus.state, RUN); end
    // Falling edge in the same cycle as a RUN exit is suppressed.
    bus.xwopen_sync = 1'b0; bus.pcie_ready_sync = 1'b0; step;
    checks++; if (bus.xw_fall !== 1'b0) begin failures++; $display("FAIL xw_exit_fall got=%b exp=0", bus.xw_fall); end
    checks++; if (bus.state !== LINK) begin failures++; $display("FAIL xw_exit_state got=%0d exp=%0d", bus.state, LINK); end
    bus.pcie_ready_sync = 1'b1;
    for (int i = 0; i <= H; i++) step;
    checks++; if (bus.state !== RUN) begin failures++; $display("FAIL xw_recover_state got=%0d exp=%0d", bus.state, RUN); end
    $display("test_xwopen done");
  endtask

  task automatic test_saturation;
    bus.locked = 1'b0; step; exp_loss++;
    // Staying low in LOCK must not count.
    step; step; step;
    checks++; if (bus.lock_loss_cnt !== 8'(exp_loss)) begin failures++; $display("FAIL sat_lock_hold got=%0d exp=%0d", bus.lock_loss_cnt, exp_loss); end
    bus.pcie_ready_sync = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus.locked = 1'b1; step;
      bus.locked = 1'b0; step;
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      if (k == 9) begin
        checks++; if (bus.lock_loss_cnt !== 8'(exp_loss)) begin failures++; $display("FAIL sat_partial got=%0d exp=%0d", bus.lock_loss_cnt, exp_loss); end
      end
    end
    checks++; if (bus.lock_loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", bus.lock_loss_cnt); end
    step; step;
    checks++; if (bus.lock_loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", bus.lock_loss_cnt); end
    checks++; if (bus.state !== LOCK) begin failures++; $display("FAIL sat_state got=%0d exp=%0d", bus.state, LOCK); end
    $display("test_saturation done");
  endtask

  task automatic test_async_reset;
    logic [1:0] exp_st;
    bus.locked = 1'b1; bus.pcie_ready_sync = 1'b1;
    step; step; step;
    checks++; if (bus.state !== HOLD) begin failures++; $display("FAIL arst_pre_state got=%0d exp=%0d", bus.state, HOLD); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.state !== LOCK) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", bus.state, LOCK); end
    checks++; if (bus.core_rst !== 1'b1) begin failures++; $display("FAIL arst_core_rst got=%b exp=1", bus.core_rst); end
    checks++; if (bus.run !== 1'b0) begin failures++; $display("FAIL arst_run got=%b exp=0", bus.run); end
    checks++; if ({bus.xw_rise, bus.xw_fall} !== 2'b00) begin failures++; $display("FAIL arst_xw got=%b%b exp=00", bus.xw_rise, bus.xw_fall); end
    checks++; if (bus.lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", bus.lock_loss_cnt); end
    step;
    rst = 1'b0;
    for (int i = 1; i <= 2 + H; i++) begin
      step;
      exp_st = (i == 1) ? LINK : (i <= 1 + H) ? HOLD : RUN;
      checks++; if (bus.state !== exp_st) begin failures++; $display("FAIL arst_reseq_state step=%0d got=%0d exp=%0d", i, bus.state, exp_st); end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_bringup;
    test_lock_drop;
    test_soft_reset;
    test_xwopen;
    test_saturation;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
